riscv_lsu_ctrl: RTL and testbench
=================================

RISCV_LSU_CTRL -- requirements
Module: riscv_lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum cycles spent in REQ plus WAIT before the access is aborted; legal range 1..255.
REQ-002 i_riscv_lsu_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 i_riscv_lsu_rst  in  1  asynchronous, active-high reset.
REQ-004 i_riscv_lsu_req  in  1  pipeline memory-op request; held stable with its operands while o_riscv_lsu_stall=1.
REQ-005 i_riscv_lsu_we  in  1  1=store, 0=load.
REQ-006 i_riscv_lsu_sel  in  3  funct3: [1:0] size (00 B, 01 H, 10 W, 11 D); [2] zero-extend (loads only).
REQ-007 i_riscv_lsu_addr  in  64  byte address.
REQ-008 i_riscv_lsu_wdata  in  64  store data, LSB-aligned.
REQ-009 o_riscv_lsu_stall  out  1  hold pipeline.
REQ-010 o_riscv_lsu_done  out  1  one-cycle completion pulse.
REQ-011 o_riscv_lsu_exc  out  2  valid with done: 00 none, 01 misaligned, 10 timeout, 11 illegal sel.
REQ-012 o_riscv_lsu_mem_valid  out  1;  i_riscv_lsu_mem_ready  in  1  request handshake.
REQ-013 o_riscv_lsu_mem_we  out  1;  o_riscv_lsu_mem_addr  out  64;  o_riscv_lsu_mem_wdata  out  64;  o_riscv_lsu_mem_strb  out  8.
REQ-014 i_riscv_lsu_mem_rvalid  in  1;  i_riscv_lsu_mem_rdata  in  64  load response.
REQ-015 o_riscv_lsu_ld_valid  out  1;  o_riscv_lsu_ld_data  out  64;  o_riscv_lsu_ld_addr  out  64;  o_riscv_lsu_ld_sel  out  3  raw doubleword plus original address and sel, passed to the memory-extension stage.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DONE; all outputs except o_riscv_lsu_stall are registered.
REQ-017 IDLE, req=1: illegal sel is 3'b111, or store with sel[2]=1 -> DONE with exc=11; else misaligned is H with addr[0]!=0, W with addr[1:0]!=0, or D with addr[2:0]!=0 -> DONE with exc=01; else -> REQ; illegal takes priority over misaligned.
REQ-018 Faulting accesses never assert mem_valid.
REQ-019 On entry to REQ, latch: mem_addr={addr[63:3],3'b000}; mem_we=we; strb = B 0x01<<addr[2:0], H 0x03<<addr[2:0], W 0x0F<<addr[2:0], D 0xFF; mem_wdata=wdata<<(8*addr[2:0]) with zero fill; ld_addr=addr; ld_sel=sel.
REQ-020 REQ: mem_valid=1, outputs stable until mem_ready=1; on handshake store -> DONE, load -> WAIT and mem_valid=0 next cycle.
REQ-021 WAIT: on rvalid=1 capture ld_data=rdata -> DONE; rvalid outside WAIT is ignored.
REQ-022 Timeout counter (8 bit) clears on IDLE->REQ and increments each cycle in REQ or WAIT; when it equals TIMEOUT_CYC-1 with no handshake/rvalid that cycle -> DONE with exc=10, mem_valid deasserted, ld_data unchanged.
REQ-023 Handshake or rvalid in the same cycle as timeout expiry wins; no exception.
REQ-024 DONE lasts exactly one cycle: done=1; ld_valid=1 only for a successful load; -> IDLE unconditionally; a request present in DONE is not re-accepted that cycle.
REQ-025 stall = (IDLE & req) | REQ | WAIT; stall=0 in DONE.
REQ-026 exc holds its value until the next DONE; exc is cleared to 00 on IDLE->REQ.

Reset
REQ-027 rst=1 asynchronously forces IDLE, counter=0, and every registered output to 0, including mid-access in REQ or WAIT.
REQ-028 A response arriving after a mid-access reset is ignored; no done pulse for the aborted access.

Verification
REQ-029 Load sel=000, addr=0x1003, ready on first REQ cycle, rvalid 2 cycles later with rdata=0x8877665544332211 -> mem_addr=0x1000, strb=0x08, ld_valid=1, ld_data=0x8877665544332211, ld_addr=0x1003, ld_sel=000, exc=00.
REQ-030 Store sel=001, addr=0x2006, wdata=0xABCD -> strb=0xC0, mem_wdata=0xABCD000000000000, done one cycle after the handshake, ld_valid=0.
REQ-031 Load sel=010, addr=0x3002 -> next cycle done=1, exc=01, mem_valid never 1; sel=111 -> exc=11.
REQ-032 TIMEOUT_CYC=4, ready held 0 -> mem_valid high 4 cycles, then done=1, exc=10; repeat with ready=1 on the 4th cycle -> exc=00.
REQ-033 Assert rst while in WAIT, then drive rvalid=1 -> all outputs 0, no done or ld_valid.
REQ-034 Back-to-back loads, req held high -> second access enters REQ only on the cycle after IDLE is re-entered from DONE; stall sequence matches REQ-025.

Source files
------------

// File: rtl/riscv_lsu_ctrl.sv
// Load/store unit control: one memory access at a time, with alignment/legality
// checks, a request/response handshake and an abort timer.
module riscv_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_riscv_lsu_clk,
  input  logic        i_riscv_lsu_rst,
  input  logic        i_riscv_lsu_req,
  input  logic        i_riscv_lsu_we,
  input  logic [2:0]  i_riscv_lsu_sel,
  input  logic [63:0] i_riscv_lsu_addr,
  input  logic [63:0] i_riscv_lsu_wdata,
  output logic        o_riscv_lsu_stall,
  output logic        o_riscv_lsu_done,
  output logic [1:0]  o_riscv_lsu_exc,
  output logic        o_riscv_lsu_mem_valid,
  input  logic        i_riscv_lsu_mem_ready,
  output logic        o_riscv_lsu_mem_we,
  output logic [63:0] o_riscv_lsu_mem_addr,
  output logic [63:0] o_riscv_lsu_mem_wdata,
  output logic [7:0]  o_riscv_lsu_mem_strb,
  input  logic        i_riscv_lsu_mem_rvalid,
  input  logic [63:0] i_riscv_lsu_mem_rdata,
  output logic        o_riscv_lsu_ld_valid,
  output logic [63:0] o_riscv_lsu_ld_data,
  output logic [63:0] o_riscv_lsu_ld_addr,
  output logic [2:0]  o_riscv_lsu_ld_sel
);

  localparam logic [7:0] LAST_CNT     = 8'(TIMEOUT_CYC - 1);
  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       illegal;
  logic       misaligned;

  function automatic logic [7:0] byte_strb(input logic [1:0] size, input logic [2:0] bofs);
    logic [7:0] s;
    case (size)
      2'b00:   s = 8'h01 << bofs;
      2'b01:   s = 8'h03 << bofs;
      2'b10:   s = 8'h0F << bofs;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // LDU (111) does not exist on RV64; stores have no zero-extend variant.
  assign illegal = (i_riscv_lsu_sel == 3'b111) | (i_riscv_lsu_we & i_riscv_lsu_sel[2]);

  always_comb begin
    case (i_riscv_lsu_sel[1:0])
      2'b01:   misaligned = i_riscv_lsu_addr[0];
      2'b10:   misaligned = |i_riscv_lsu_addr[1:0];
      2'b11:   misaligned = |i_riscv_lsu_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign o_riscv_lsu_stall = ((state == IDLE) & i_riscv_lsu_req) | (state == REQ) | (state == WAIT);

  always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
    if (i_riscv_lsu_rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      o_riscv_lsu_done      <= 1'b0;
      o_riscv_lsu_exc       <= EXC_NONE;
      o_riscv_lsu_mem_valid <= 1'b0;
      o_riscv_lsu_mem_we    <= 1'b0;
      o_riscv_lsu_mem_addr  <= '0;
      o_riscv_lsu_mem_wdata <= '0;
      o_riscv_lsu_mem_strb  <= '0;
      o_riscv_lsu_ld_valid  <= 1'b0;
      o_riscv_lsu_ld_data   <= '0;
      o_riscv_lsu_ld_addr   <= '0;
      o_riscv_lsu_ld_sel    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_riscv_lsu_req) begin
            if (illegal) begin
              state            <= DONE;
              o_riscv_lsu_done <= 1'b1;
              o_riscv_lsu_exc  <= EXC_ILLEGAL;
            end else if (misaligned) begin
              state            <= DONE;
              o_riscv_lsu_done <= 1'b1;
              o_riscv_lsu_exc  <= EXC_MISALIGN;
            end else begin
              state                 <= REQ;
              cnt                   <= '0;
              o_riscv_lsu_exc       <= EXC_NONE;
              o_riscv_lsu_mem_valid <= 1'b1;
              o_riscv_lsu_mem_we    <= i_riscv_lsu_we;
              o_riscv_lsu_mem_addr  <= {i_riscv_lsu_addr[63:3], 3'b000};
              o_riscv_lsu_mem_strb  <= byte_strb(i_riscv_lsu_sel[1:0], i_riscv_lsu_addr[2:0]);
              o_riscv_lsu_mem_wdata <= i_riscv_lsu_wdata << {i_riscv_lsu_addr[2:0], 3'b000};
              o_riscv_lsu_ld_addr   <= i_riscv_lsu_addr;
              o_riscv_lsu_ld_sel    <= i_riscv_lsu_sel;
            end
          end
        end
        // A handshake on the expiry cycle still completes normally.
        REQ: begin
          if (i_riscv_lsu_mem_ready) begin
            o_riscv_lsu_mem_valid <= 1'b0;
            cnt                   <= cnt + 8'd1;
            if (o_riscv_lsu_mem_we) begin
              state            <= DONE;
              o_riscv_lsu_done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else if (cnt == LAST_CNT) begin
            state                 <= DONE;
            o_riscv_lsu_mem_valid <= 1'b0;
            o_riscv_lsu_done      <= 1'b1;
            o_riscv_lsu_exc       <= EXC_TIMEOUT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT: begin
          if (i_riscv_lsu_mem_rvalid) begin
            state                <= DONE;
            o_riscv_lsu_ld_data  <= i_riscv_lsu_mem_rdata;
            o_riscv_lsu_ld_valid <= 1'b1;
            o_riscv_lsu_done     <= 1'b1;
          end else if (cnt == LAST_CNT) begin
            state            <= DONE;
            o_riscv_lsu_done <= 1'b1;
            o_riscv_lsu_exc  <= EXC_TIMEOUT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state                <= IDLE;
          o_riscv_lsu_done     <= 1'b0;
          o_riscv_lsu_ld_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Bench for riscv_lsu_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_riscv_lsu_ctrl;

  localparam int TO_CYC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        mem_ready = 1'b0;
  logic        rvalid = 1'b0;
  logic [63:0] rdata = '0;

  logic        stall, done, mem_valid, mem_we, ld_valid;
  logic [1:0]  exc;
  logic [63:0] mem_addr, mem_wdata, ld_data, ld_addr;
  logic [7:0]  strb;
  logic [2:0]  ld_sel;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;
  int cyc;

  riscv_lsu_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
    .i_riscv_lsu_clk       (clk),
    .i_riscv_lsu_rst       (rst),
    .i_riscv_lsu_req       (req),
    .i_riscv_lsu_we        (we),
    .i_riscv_lsu_sel       (sel),
    .i_riscv_lsu_addr      (addr),
    .i_riscv_lsu_wdata     (wdata),
    .o_riscv_lsu_stall     (stall),
    .o_riscv_lsu_done      (done),
    .o_riscv_lsu_exc       (exc),
    .o_riscv_lsu_mem_valid (mem_valid),
    .i_riscv_lsu_mem_ready (mem_ready),
    .o_riscv_lsu_mem_we    (mem_we),
    .o_riscv_lsu_mem_addr  (mem_addr),
    .o_riscv_lsu_mem_wdata (mem_wdata),
    .o_riscv_lsu_mem_strb  (strb),
    .i_riscv_lsu_mem_rvalid(rvalid),
    .i_riscv_lsu_mem_rdata (rdata),
    .o_riscv_lsu_ld_valid  (ld_valid),
    .o_riscv_lsu_ld_data   (ld_data),
    .o_riscv_lsu_ld_addr   (ld_addr),
    .o_riscv_lsu_ld_sel    (ld_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 request offered, 2 awaiting data, 3 completion cycle.
  // m_n counts the cycles the access has already spent in phases 1 and 2.
  int          m_ph = 0;
  int          m_n = 0;
  int          m_sz, m_ofs;
  logic        e_done = 0, e_mv = 0, e_mwe = 0, e_ldv = 0;
  logic [1:0]  e_exc = 0;
  logic [63:0] e_maddr = 0, e_mwd = 0, e_ldd = 0, e_lda = 0;
  logic [7:0]  e_strb = 0;
  logic [2:0]  e_lds = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_ph = 0; m_n = 0;
      e_done = 0; e_mv = 0; e_mwe = 0; e_ldv = 0; e_exc = 0;
      e_maddr = 0; e_mwd = 0; e_ldd = 0; e_lda = 0; e_strb = 0; e_lds = 0;
    end else begin
      case (m_ph)
        0: if (req) begin
          m_sz  = 1 << sel[1:0];
          m_ofs = int'(addr[2:0]);
          if (sel == 3'b111 || (we && sel[2])) begin
            m_ph = 3; e_done = 1; e_exc = 2'b11;
          end else if ((m_ofs % m_sz) != 0) begin
            m_ph = 3; e_done = 1; e_exc = 2'b01;
          end else begin
            m_ph = 1; m_n = 0; e_exc = 0; e_mv = 1; e_mwe = we;
            e_maddr = addr - 64'(m_ofs); e_lda = addr; e_lds = sel;
            for (int b = 0; b < 8; b++) begin
              e_strb[b] = (b >= m_ofs) && (b < m_ofs + m_sz);
              e_mwd[8*b +: 8] = 8'h00;
              if (b >= m_ofs) e_mwd[8*b +: 8] = wdata[8*(b-m_ofs) +: 8];
            end
          end
        end
        1: begin
          if (mem_ready) begin
            e_mv = 0;
            if (e_mwe) begin m_ph = 3; e_done = 1; end
            else begin m_ph = 2; m_n++; end
          end else if ((m_n % 256) == TO_CYC - 1) begin
            e_mv = 0; m_ph = 3; e_done = 1; e_exc = 2'b10;
          end else m_n++;
        end
        2: begin
          if (rvalid) begin
            e_ldd = rdata; e_ldv = 1; e_done = 1; m_ph = 3;
          end else if ((m_n % 256) == TO_CYC - 1) begin
            m_ph = 3; e_done = 1; e_exc = 2'b10;
          end else m_n++;
        end
        default: begin
          e_done = 0; e_ldv = 0; m_ph = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_stall", 64'(stall), 64'((m_ph == 0 && req) || m_ph == 1 || m_ph == 2));
      chk("cyc_done", 64'(done), 64'(e_done));
      chk("cyc_exc", 64'(exc), 64'(e_exc));
      chk("cyc_mem_valid", 64'(mem_valid), 64'(e_mv));
      chk("cyc_mem_we", 64'(mem_we), 64'(e_mwe));
      chk("cyc_mem_addr", mem_addr, e_maddr);
      chk("cyc_mem_wdata", mem_wdata, e_mwd);
      chk("cyc_mem_strb", 64'(strb), 64'(e_strb));
      chk("cyc_ld_valid", 64'(ld_valid), 64'(e_ldv));
      chk("cyc_ld_data", ld_data, e_ldd);
      chk("cyc_ld_addr", ld_addr, e_lda);
      chk("cyc_ld_sel", 64'(ld_sel), 64'(e_lds));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      mem_ready = ($urandom % 4) == 0;
      rvalid    = ($urandom % 3) == 0;
      rdata     = {$urandom, $urandom};
    end
  endtask

  task automatic rand_op();
    we    = 1'($urandom % 2);
    sel   = 3'($urandom % 8);
    addr  = {$urandom, $urandom};
    if ($urandom % 2) addr[2:0] = addr[2:0] & ~3'((1 << sel[1:0]) - 1);
    wdata = {$urandom, $urandom};
    req   = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_exc", 64'(exc), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_ld_valid", 64'(ld_valid), 64'(0));
    step();
    rst = 1'b0;
    step();

    // Byte load at offset 3, data returned two cycles after the handshake
    we = 0; sel = 3'b000; addr = 64'h1003; req = 1; mem_ready = 1;
    step();
    chk("a_mem_valid", 64'(mem_valid), 64'(1));
    chk("a_mem_addr", mem_addr, 64'h1000);
    chk("a_strb", 64'(strb), 64'h08);
    step();
    mem_ready = 0;
    chk("a_wait_mem_valid", 64'(mem_valid), 64'(0));
    step();
    rvalid = 1; rdata = 64'h8877665544332211;
    step();
    rvalid = 0;
    chk("a_done", 64'(done), 64'(1));
    chk("a_ld_valid", 64'(ld_valid), 64'(1));
    chk("a_ld_data", ld_data, 64'h8877665544332211);
    chk("a_ld_addr", ld_addr, 64'h1003);
    chk("a_ld_sel", 64'(ld_sel), 64'(0));
    chk("a_exc", 64'(exc), 64'(0));
    chk("a_stall_done", 64'(stall), 64'(0));
    req = 0;
    step();
    chk("a_done_pulse", 64'(done), 64'(0));

    // Halfword store at offset 6
    we = 1; sel = 3'b001; addr = 64'h2006; wdata = 64'hABCD; req = 1; mem_ready = 1;
    step();
    chk("b_strb", 64'(strb), 64'hC0);
    chk("b_mem_wdata", mem_wdata, 64'hABCD000000000000);
    chk("b_mem_we", 64'(mem_we), 64'(1));
    step();
    mem_ready = 0;
    chk("b_done", 64'(done), 64'(1));
    chk("b_ld_valid", 64'(ld_valid), 64'(0));
    req = 0;
    step();

    // Faults: misaligned word, illegal sel, illegal beats misaligned
    we = 0; sel = 3'b010; addr = 64'h3002; req = 1;
    step();
    chk("c_mis_done", 64'(done), 64'(1));
    chk("c_mis_exc", 64'(exc), 64'h1);
    chk("c_mis_mem_valid", 64'(mem_valid), 64'(0));
    req = 0;
    step();
    chk("c_exc_holds", 64'(exc), 64'h1);
    sel = 3'b111; addr = 64'h3000; req = 1;
    step();
    chk("c_ill_exc", 64'(exc), 64'h3);
    req = 0;
    step();
    we = 1; sel = 3'b101; addr = 64'h3001; req = 1;
    step();
    chk("c_ill_prio_exc", 64'(exc), 64'h3);
    req = 0;
    step();

    // Timeout with ready held low
    we = 0; sel = 3'b011; addr = 64'h4000; req = 1; mem_ready = 0;
    for (int i = 0; i < TO_CYC; i++) begin
      step();
      chk("d_mem_valid_held", 64'(mem_valid), 64'(1));
    end
    step();
    chk("d_to_done", 64'(done), 64'(1));
    chk("d_to_exc", 64'(exc), 64'h2);
    chk("d_to_mem_valid", 64'(mem_valid), 64'(0));
    chk("d_to_ld_valid", 64'(ld_valid), 64'(0));
    chk("d_to_ld_data_kept", ld_data, 64'h8877665544332211);
    req = 0;
    step();
    chk("d_exc_holds", 64'(exc), 64'h2);

    // Handshake on the expiry cycle wins
    we = 1; sel = 3'b011; addr = 64'h4008; wdata = 64'h0123456789ABCDEF; req = 1;
    step();
    chk("d_exc_cleared", 64'(exc), 64'h0);
    step(); step(); step();
    mem_ready = 1;
    step();
    mem_ready = 0;
    chk("d_late_done", 64'(done), 64'(1));
    chk("d_late_exc", 64'(exc), 64'h0);
    req = 0;
    step();

    // rvalid on the expiry cycle wins
    we = 0; sel = 3'b011; addr = 64'h4010; req = 1; mem_ready = 1;
    step(); step();
    mem_ready = 0;
    step(); step();
    rvalid = 1; rdata = 64'hCAFEF00D12345678;
    step();
    rvalid = 0;
    chk("d_rv_done", 64'(done), 64'(1));
    chk("d_rv_exc", 64'(exc), 64'h0);
    chk("d_rv_ld_data", ld_data, 64'hCAFEF00D12345678);
    req = 0;
    step();

    // Reset while waiting for load data
    we = 0; sel = 3'b011; addr = 64'h5000; req = 1; mem_ready = 1;
    step(); step();
    mem_ready = 0; req = 0;
    chk("e_stall_wait", 64'(stall), 64'(1));
    #2 rst = 1;
    #1;
    chk("e_rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("e_rst_mem_addr", mem_addr, 64'(0));
    chk("e_rst_ld_addr", ld_addr, 64'(0));
    chk("e_rst_stall", 64'(stall), 64'(0));
    step();
    rst = 0; rvalid = 1; rdata = 64'hDEAD;
    step(); step();
    rvalid = 0;
    chk("e_no_done", 64'(done), 64'(0));
    chk("e_no_ld_valid", 64'(ld_valid), 64'(0));
    chk("e_ld_data_clear", ld_data, 64'(0));

    // Back-to-back loads with req held high
    we = 0; sel = 3'b011; addr = 64'h6000; req = 1; mem_ready = 1; rvalid = 1; rdata = 64'h1111;
    step();
    chk("f_stall_req", 64'(stall), 64'(1));
    step();
    chk("f_stall_wait", 64'(stall), 64'(1));
    step();
    chk("f_done", 64'(done), 64'(1));
    chk("f_stall_done", 64'(stall), 64'(0));
    addr = 64'h6008;
    step();
    chk("f_idle_stall", 64'(stall), 64'(1));
    chk("f_idle_mem_valid", 64'(mem_valid), 64'(0));
    step();
    chk("f_req2_mem_valid", 64'(mem_valid), 64'(1));
    chk("f_req2_mem_addr", mem_addr, 64'h6008);
    step(); step();
    chk("f_done2", 64'(done), 64'(1));
    req = 0; mem_ready = 0; rvalid = 0;
    step();

    // Randomized traffic, including back-to-back and rvalid outside WAIT
    rand_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      rand_op();
      cyc = 0;
      do begin
        step();
        cyc++;
      end while (done !== 1'b1 && cyc < 400);
      chk("rand_op_completes", 64'(done), 64'(1));
      if ($urandom % 2) begin
        req = 0;
        repeat ($urandom % 3) step();
      end
    end
    req = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
